// File: rtl/util_delay_pipe.sv
// util_delay_pipe: valid-tagged multi-bit delay line with whole-pipe stall and flush.
// Keeps a datapath word aligned with the single-bit control delay lines downstream.
package util_delay_pipe_pkg;
    typedef struct packed {
        logic clk;
        logic rst_n;
    } Data_Control_Control_T;
endpackage

module util_delay_pipe
    import util_delay_pipe_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter int               DELAY = 3,
    parameter logic [WIDTH-1:0] RESET = '0,
    localparam int              CW    = ($clog2(DELAY + 1) > 1) ? $clog2(DELAY + 1) : 1
) (
    input  Data_Control_Control_T ctrl,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [CW-1:0]         count,
    output logic                  busy
);

    if (DELAY == 0) begin : g_pass
        // No storage at all: clock, reset and stall have nothing to act on.
        logic unused_inputs;
        assign unused_inputs = &{1'b0, stall, ctrl};

        assign out_valid = in_valid & ~flush;
        assign out_data  = out_valid ? in_data : RESET;
        assign count     = '0;
        assign busy      = 1'b0;
    end else begin : g_pipe
        logic             clk;
        logic             rst_n;
        logic [DELAY-1:0] v;
        logic [WIDTH-1:0] d [DELAY];
        logic [CW-1:0]    cnt;

        assign clk   = ctrl.clk;
        assign rst_n = ctrl.rst_n;

        // Invalid slots always carry RESET so out_data is clean whenever out_valid is low.
        always_ff @(posedge clk) begin
            if (!rst_n || flush) begin
                v   <= '0;
                cnt <= '0;
                for (int i = 0; i < DELAY; i++) begin
                    d[i] <= RESET;
                end
            end else if (!stall) begin
                v[0] <= in_valid;
                d[0] <= in_valid ? in_data : RESET;
                for (int i = 1; i < DELAY; i++) begin
                    v[i] <= v[i-1];
                    d[i] <= d[i-1];
                end
                // Modular arithmetic: a full pipe taking and emitting together nets to DELAY.
                cnt <= cnt + CW'(in_valid) - CW'(v[DELAY-1]);
            end
        end

        assign out_valid = v[DELAY-1];
        assign out_data  = d[DELAY-1];
        assign count     = cnt;
        assign busy      = (cnt != '0);
    end

endmodule

// File: tb/tb_util_delay_pipe.sv
// Scoreboard bench for util_delay_pipe: a DELAY=3 pipe checked against a queue model
// and a DELAY=0 pass-through checked combinationally on the same stimulus.
module tb_util_delay_pipe;
    import util_delay_pipe_pkg::*;

    localparam int W = 8;
    localparam int D = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    Data_Control_Control_T ctrl;
    assign ctrl = {clk, rst_n};

    logic         stall    = 1'b0;
    logic         flush    = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = '0;

    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   count;
    logic         busy;
    logic         out_valid0;
    logic [W-1:0] out_data0;
    logic [0:0]   count0;
    logic         busy0;

    util_delay_pipe #(.WIDTH(W), .DELAY(D), .RESET(8'h00)) dut (
        .ctrl(ctrl), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .count(count), .busy(busy)
    );

    util_delay_pipe #(.WIDTH(W), .DELAY(0), .RESET(8'h00)) dut0 (
        .ctrl(ctrl), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid0), .out_data(out_data0), .count(count0), .busy(busy0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
    } ent_t;

    ent_t q[$];
    ent_t expOut;
    int   total = 0;
    int   bad   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int expCount();
        int c = int'(expOut.v);
        foreach (q[i]) c += int'(q[i].v);
        return c;
    endfunction

    // The queue holds the D-1 younger slots; expOut is the oldest one, at the output.
    task automatic clearModel();
        q.delete();
        for (int i = 0; i < D - 1; i++) q.push_back('0);
        expOut = '0;
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic f,
                                 input logic v, input logic [W-1:0] dat);
        rst_n    = r;
        stall    = s;
        flush    = f;
        in_valid = v;
        in_data  = dat;
        @(posedge clk);
        #1;
        if (!r || f) begin
            clearModel();
        end else if (!s) begin
            q.push_back('{v: v, d: (v ? dat : 8'h00)});
            expOut = q.pop_front();
        end
        checkOutput("out_valid", 32'(out_valid), 32'(expOut.v));
        checkOutput("out_data", 32'(out_data), 32'(expOut.d));
        checkOutput("count", 32'(count), 32'(expCount()));
        checkOutput("busy", 32'(busy), 32'(expCount() != 0));
        checkOutput("d0_valid", 32'(out_valid0), 32'(v & ~f));
        checkOutput("d0_data", 32'(out_data0), 32'((v & ~f) ? dat : 8'h00));
        checkOutput("d0_count", 32'(count0), 32'd0);
        checkOutput("d0_busy", 32'(busy0), 32'd0);
    endtask

    initial begin
        int cseq[7];
        logic [W-1:0] sdat[4];
        cseq = '{1, 2, 3, 3, 2, 1, 0};
        sdat = '{8'h11, 8'h22, 8'h33, 8'h44};
        clearModel();

        $display("[TB] reset with live input");
        applyStimulus(0, 0, 0, 1, 8'hAA);
        applyStimulus(0, 0, 0, 1, 8'hAA);
        applyStimulus(1, 0, 0, 0, 8'h00);

        $display("[TB] four-entry stream");
        for (int i = 0; i < 7; i++) begin
            if (i < 4) applyStimulus(1, 0, 0, 1, sdat[i]);
            else       applyStimulus(1, 0, 0, 0, 8'h00);
            checkOutput("stream_count", 32'(count), 32'(cseq[i]));
            if (i >= 2 && i <= 5) begin
                checkOutput("stream_valid", 32'(out_valid), 32'd1);
                checkOutput("stream_data", 32'(out_data), 32'(sdat[i-2]));
            end
        end

        $display("[TB] stall holds the line");
        applyStimulus(1, 0, 0, 1, 8'h11);
        applyStimulus(1, 0, 0, 1, 8'h22);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 0, 1, 8'h99);
            checkOutput("stall_count", 32'(count), 32'd2);
            checkOutput("stall_valid", 32'(out_valid), 32'd0);
        end
        applyStimulus(1, 0, 0, 0, 8'h00);
        checkOutput("stall_lat_data", 32'(out_data), 32'h11);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 8'h00);

        $display("[TB] flush with live input");
        applyStimulus(1, 0, 0, 1, 8'h11);
        applyStimulus(1, 0, 0, 1, 8'h22);
        applyStimulus(1, 0, 0, 1, 8'h33);
        checkOutput("pre_flush_count", 32'(count), 32'd3);
        applyStimulus(1, 0, 1, 1, 8'h55);
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_data", 32'(out_data), 32'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 8'h00);

        $display("[TB] flush with stall, then bubbles");
        applyStimulus(1, 0, 0, 1, 8'h11);
        applyStimulus(1, 0, 0, 1, 8'h22);
        applyStimulus(1, 1, 1, 1, 8'h66);
        checkOutput("flush_stall_count", 32'(count), 32'd0);
        applyStimulus(1, 0, 0, 1, 8'h01);
        applyStimulus(1, 0, 0, 0, 8'h00);
        applyStimulus(1, 0, 0, 1, 8'h03);
        checkOutput("bubble_v0", 32'(out_valid), 32'd1);
        checkOutput("bubble_d0", 32'(out_data), 32'h01);
        applyStimulus(1, 0, 0, 0, 8'h00);
        checkOutput("bubble_v1", 32'(out_valid), 32'd0);
        checkOutput("bubble_d1", 32'(out_data), 32'h00);
        applyStimulus(1, 0, 0, 0, 8'h00);
        checkOutput("bubble_v2", 32'(out_valid), 32'd1);
        checkOutput("bubble_d2", 32'(out_data), 32'h03);
        applyStimulus(1, 0, 0, 0, 8'h00);

        $display("[TB] pass-through corner");
        applyStimulus(1, 0, 0, 1, 8'h7E);
        applyStimulus(1, 0, 1, 1, 8'h7E);

        $display("[TB] random traffic with mid-stream reset");
        for (int i = 0; i < 60; i++) begin
            applyStimulus((i == 30) ? 1'b0 : 1'b1,
                          ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 3) != 0),
                          8'($urandom_range(1, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
